// File: rtl/uart_wpack_pkg.sv
// Shared constants for the UART word packer: FSM state encodings and width helpers.
// Pure declarations: no latency, no backpressure.
package uart_wpack_pkg;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_WAIT = 2'd1;
    localparam logic [1:0] TX_SEND = 2'd2;
    localparam logic [1:0] TX_DONE = 2'd3;

    localparam logic [1:0] RX_IDLE    = 2'd0;
    localparam logic [1:0] RX_COLLECT = 2'd1;
    localparam logic [1:0] RX_DONE    = 2'd2;

    // Width of a byte-count register able to hold 0..word_bytes.
    function automatic int cvl_width(input int word_bytes);
        return $clog2(word_bytes + 1);
    endfunction

    // Width of a counter that must reach max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for the RX path: write-to-read 1 cycle, combinational read of the head entry.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int FW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [FW-1:0] free
);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == FW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign free    = FW'(DEPTH) - cnt_q;
    assign dout    = mem_q[rptr_q];
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + FW'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_wpack.sv
// Packs words into serial-core bytes (MSB byte first) and reassembles received bytes into words.
// RX byte to rx_word in 2 cycles min; TX waits on cts_n and txb_ready; RX bytes are dropped when the FIFO is full.
module uart_wpack
    import uart_wpack_pkg::*;
#(
    parameter int WORD_BYTES = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1024,
    parameter int RTS_MARGIN = 4,
    localparam int CW = cvl_width(WORD_BYTES),
    localparam int W  = 8 * WORD_BYTES,
    localparam int FW = $clog2(FIFO_DEPTH) + 1,
    localparam int TW = cnt_width(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cmd,
    input  logic          wr_txc,
    input  logic          wr_rxc,
    input  logic [W-1:0]  tx_word,
    input  logic          tx_load,
    output logic          tx_busy,
    output logic [W-1:0]  rx_word,
    output logic [CW-1:0] rx_nbytes,
    output logic          rx_avail,
    input  logic          rx_take,
    output logic [7:0]    txb_data,
    output logic          txb_valid,
    input  logic          txb_ready,
    input  logic [7:0]    rxb_data,
    input  logic          rxb_valid,
    input  logic          cts_n,
    output logic          rts,
    output logic          rx_overrun
);

    function automatic logic [CW-1:0] clamp_cvl(input logic [CW-1:0] v);
        return (v > CW'(WORD_BYTES)) ? CW'(WORD_BYTES) : v;
    endfunction

    logic [CW-1:0] txc_q, txc_d;
    logic [CW-1:0] rxc_q, rxc_d;

    logic [1:0]    tx_state_q, tx_state_d;
    logic [W-1:0]  tx_word_q, tx_word_d;
    logic [CW-1:0] tx_rem_q, tx_rem_d;

    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cvl_q, rx_cvl_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [W-1:0]  rx_word_q, rx_word_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          rts_q, rts_d;
    logic          ovr_q, ovr_d;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [FW-1:0] fifo_free;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rxb_valid),
        .din   (rxb_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    always_comb begin
        txc_d = wr_txc ? clamp_cvl(cmd) : txc_q;
        rxc_d = wr_rxc ? clamp_cvl(cmd) : rxc_q;
    end

    // The word is shifted left on each accepted byte so the outgoing byte always sits at the top.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_word_d  = tx_word_q;
        tx_rem_d   = tx_rem_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_load) begin
                    tx_state_d = TX_WAIT;
                    tx_word_d  = tx_word;
                    tx_rem_d   = txc_q;
                end
            end
            TX_WAIT: begin
                if (!cts_n) begin
                    tx_state_d = (tx_rem_q == '0) ? TX_DONE : TX_SEND;
                end
            end
            TX_SEND: begin
                if (txb_ready) begin
                    tx_word_d  = tx_word_q << 8;
                    tx_rem_d   = tx_rem_q - CW'(1);
                    tx_state_d = (tx_rem_q == CW'(1)) ? TX_DONE : TX_WAIT;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cvl_d   = rx_cvl_q;
        rx_cnt_d   = rx_cnt_q;
        rx_word_d  = rx_word_q;
        idle_d     = idle_q;
        fifo_pop   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxc_q != '0) begin
                    rx_state_d = RX_COLLECT;
                    rx_cvl_d   = rxc_q;
                    rx_cnt_d   = '0;
                    rx_word_d  = '0;
                    idle_d     = '0;
                end
            end
            RX_COLLECT: begin
                if (rx_cnt_q == rx_cvl_q) begin
                    rx_state_d = RX_DONE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rx_word_d[W-1-8*int'(rx_cnt_q) -: 8] = fifo_dout;
                    rx_cnt_d = rx_cnt_q + CW'(1);
                    idle_d   = '0;
                end else if ((TIMEOUT != 0) && (rx_cnt_q != '0)) begin
                    // Deliver a partial word once TIMEOUT pop-less cycles have elapsed.
                    if (idle_q == TW'(TIMEOUT - 1)) begin
                        rx_state_d = RX_DONE;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
            end
            RX_DONE: begin
                if (rx_take) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rts_d = (rxc_q != '0) && (int'(fifo_free) > RTS_MARGIN);
        ovr_d = ovr_q;
        if (wr_rxc) begin
            ovr_d = 1'b0;
        end
        // A drop in the same cycle as the clear still counts as lost data.
        if (rxb_valid && fifo_full && !fifo_pop) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txc_q      <= '0;
            rxc_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_word_q  <= '0;
            tx_rem_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_cvl_q   <= '0;
            rx_cnt_q   <= '0;
            rx_word_q  <= '0;
            idle_q     <= '0;
            rts_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            txc_q      <= txc_d;
            rxc_q      <= rxc_d;
            tx_state_q <= tx_state_d;
            tx_word_q  <= tx_word_d;
            tx_rem_q   <= tx_rem_d;
            rx_state_q <= rx_state_d;
            rx_cvl_q   <= rx_cvl_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_word_q  <= rx_word_d;
            idle_q     <= idle_d;
            rts_q      <= rts_d;
            ovr_q      <= ovr_d;
        end
    end

    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign txb_valid  = (tx_state_q == TX_SEND);
    assign txb_data   = txb_valid ? tx_word_q[W-1 -: 8] : 8'h00;
    assign rx_word    = rx_word_q;
    assign rx_nbytes  = rx_cnt_q;
    assign rx_avail   = (rx_state_q == RX_DONE);
    assign rts        = rts_q;
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_wpack.sv
module tb_uart_wpack;

    localparam int DEPTH  = 16;
    localparam int TMO    = 16;
    localparam int MARGIN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cmd;
    logic        wr_txc, wr_rxc;
    logic [63:0] tx_word;
    logic        tx_load, tx_busy;
    logic [63:0] rx_word;
    logic [3:0]  rx_nbytes;
    logic        rx_avail, rx_take;
    logic [7:0]  txb_data;
    logic        txb_valid, txb_ready;
    logic [7:0]  rxb_data;
    logic        rxb_valid;
    logic        cts_n, rts, rx_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_wpack #(
        .WORD_BYTES (8),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .RTS_MARGIN (MARGIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .wr_txc     (wr_txc),
        .wr_rxc     (wr_rxc),
        .tx_word    (tx_word),
        .tx_load    (tx_load),
        .tx_busy    (tx_busy),
        .rx_word    (rx_word),
        .rx_nbytes  (rx_nbytes),
        .rx_avail   (rx_avail),
        .rx_take    (rx_take),
        .txb_data   (txb_data),
        .txb_valid  (txb_valid),
        .txb_ready  (txb_ready),
        .rxb_data   (rxb_data),
        .rxb_valid  (rxb_valid),
        .cts_n      (cts_n),
        .rts        (rts),
        .rx_overrun (rx_overrun)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [63:0] word;
        int          stall;
        int          exp_n;
        logic [63:0] exp_stream;
    } tx_vec_t;

    typedef struct {
        logic [3:0]  cmd;
        int          nin;
        logic [63:0] in_bytes;
        logic [63:0] exp_word;
        logic [3:0]  exp_n;
    } rx_vec_t;

    tx_vec_t txv[5];
    rx_vec_t rxv[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rxb_data  = b;
        rxb_valid = 1'b1;
        tick();
        rxb_valid = 1'b0;
    endtask

    task automatic wait_avail(input string name);
        int n;
        n = 0;
        while (!rx_avail && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(rx_avail), 64'd1);
    endtask

    // Sends one word, stalling txb_ready `stall` cycles per byte and holding cts_n high
    // for `cts_hold` cycles; optionally pokes tx_load/wr_txc mid-send.
    task automatic run_tx(input logic do_wr, input logic [3:0] c, input logic [63:0] w,
                          input int stall, input int cts_hold, input logic inject,
                          output int n, output logic [63:0] stream);
        int sc, cyc;
        logic pend, cts_edge;
        logic [7:0] pdat;
        sc = 0; cyc = 0; pend = 1'b0; pdat = 8'h00;
        n = 0; stream = '0;
        if (do_wr) begin
            cmd = c; wr_txc = 1'b1; tick(); wr_txc = 1'b0;
        end
        tx_word = w; tx_load = 1'b1; cts_n = (cts_hold > 0);
        cts_edge = cts_n;
        tick();
        tx_load = 1'b0;
        check("tx_busy_rise", 64'(tx_busy), 64'd1);
        while (tx_busy && cyc < 400) begin
            if (pend) check("txb_hold", {55'd0, txb_valid, txb_data}, {55'd0, 1'b1, pdat});
            if (cts_edge) check("no_valid_while_cts", 64'(txb_valid), 64'd0);
            pend = 1'b0;
            if (txb_valid) begin
                if (sc >= stall) begin
                    txb_ready = 1'b1;
                    if (n < 8) stream[63-8*n -: 8] = txb_data;
                    n++;
                    sc = 0;
                end else begin
                    txb_ready = 1'b0;
                    sc++;
                    pend = 1'b1;
                    pdat = txb_data;
                end
            end else begin
                txb_ready = 1'b0;
            end
            cts_n = (cyc < cts_hold);
            cts_edge = cts_n;
            if (inject && cyc == 2) begin
                tx_load = 1'b1; tx_word = 64'hFFFF_FFFF_FFFF_FFFF;
                cmd = 4'd3; wr_txc = 1'b1;
            end
            tick();
            cyc++;
            tx_load = 1'b0; wr_txc = 1'b0;
        end
        txb_ready = 1'b0;
        cts_n = 1'b0;
        check("tx_done_in_time", 64'(tx_busy), 64'd0);
    endtask

    initial begin
        int n, acc, seen;
        logic [63:0] s;
        logic [7:0] exp_b;

        txv[0] = '{4'd8,  64'h0102030405060708, 3, 8, 64'h0102030405060708};
        txv[1] = '{4'd2,  64'h0102030405060708, 0, 2, 64'h0102000000000000};
        txv[2] = '{4'd0,  64'h1122334455667788, 0, 0, 64'h0000000000000000};
        txv[3] = '{4'd12, 64'hDEADBEEFCAFEF00D, 1, 8, 64'hDEADBEEFCAFEF00D};
        txv[4] = '{4'd1,  64'hA5C3000000000011, 2, 1, 64'hA500000000000000};

        rxv[0] = '{4'd4,  4, 64'hAABBCCDD00000000, 64'hAABBCCDD00000000, 4'd4};
        rxv[1] = '{4'd15, 8, 64'h1122334455667788, 64'h1122334455667788, 4'd8};
        rxv[2] = '{4'd1,  1, 64'h5A00000000000000, 64'h5A00000000000000, 4'd1};
        rxv[3] = '{4'd8,  3, 64'h1020300000000000, 64'h1020300000000000, 4'd3};

        rst = 1'b1; cmd = '0; wr_txc = 1'b0; wr_rxc = 1'b0; tx_word = '0; tx_load = 1'b0;
        rx_take = 1'b0; txb_ready = 1'b0; rxb_data = '0; rxb_valid = 1'b0; cts_n = 1'b0;
        tick();
        tick();
        check("reset_word", rx_word, 64'd0);
        check("reset_ctl", {48'd0, tx_busy, txb_valid, txb_data, rx_nbytes, rx_avail, rts, rx_overrun},
              64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_tx(1'b1, txv[i].cmd, txv[i].word, txv[i].stall, 0, 1'b0, n, s);
            check($sformatf("tx_count_%0d", i), 64'(n), 64'(txv[i].exp_n));
            check($sformatf("tx_bytes_%0d", i), s, txv[i].exp_stream);
        end

        // CTS held off, with an ignored tx_load and a CVL change mid-word.
        run_tx(1'b1, 4'd2, 64'h0102030405060708, 0, 10, 1'b1, n, s);
        check("cts_count", 64'(n), 64'd2);
        check("cts_bytes", s, 64'h0102000000000000);
        run_tx(1'b0, 4'd0, 64'h0A0B0C0D0E0F1011, 0, 0, 1'b0, n, s);
        check("next_cvl_count", 64'(n), 64'd3);
        check("next_cvl_bytes", s, 64'h0A0B0C0000000000);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            cmd = rxv[i].cmd; wr_rxc = 1'b1; tick(); wr_rxc = 1'b0;
            tick();
            for (int k = 0; k < rxv[i].nin; k++) rx_send(rxv[i].in_bytes[63-8*k -: 8]);
            wait_avail($sformatf("rx_avail_%0d", i));
            check($sformatf("rx_word_%0d", i), rx_word, rxv[i].exp_word);
            check($sformatf("rx_nbytes_%0d", i), 64'(rx_nbytes), 64'(rxv[i].exp_n));
            rx_take = 1'b1; tick(); rx_take = 1'b0;
            check($sformatf("rx_take_%0d", i), 64'(rx_avail), 64'd0);
        end

        // Latency and exact timeout distance.
        do_reset();
        cmd = 4'd8; wr_rxc = 1'b1; tick(); wr_rxc = 1'b0;
        tick();
        rx_send(8'h10);
        check("lat_fifo_only", 64'(rx_nbytes), 64'd0);
        rx_send(8'h20);
        check("lat_stored", 64'(rx_nbytes), 64'd1);
        rx_send(8'h30);
        n = 0;
        while (rx_nbytes != 4'd3 && n < 50) begin tick(); n++; end
        check("tmo_three_stored", 64'(rx_nbytes), 64'd3);
        n = 0;
        while (!rx_avail && n < 100) begin tick(); n++; end
        check("tmo_cycles", 64'(n), 64'(TMO));
        check("tmo_nbytes", 64'(rx_nbytes), 64'd3);

        // CVL 0 leaves bytes in the FIFO until a CVL is written.
        do_reset();
        rx_send(8'h31); rx_send(8'h32); rx_send(8'h33);
        repeat (5) tick();
        check("cvl0_no_avail", {62'd0, rx_avail, rts}, 64'd0);
        cmd = 4'd3; wr_rxc = 1'b1; tick(); wr_rxc = 1'b0;
        wait_avail("cvl0_late_avail");
        check("cvl0_word", rx_word, 64'h3132330000000000);

        // Fill the FIFO behind a completed word: rts, overrun, full push+pop.
        do_reset();
        cmd = 4'd1; wr_rxc = 1'b1; tick(); wr_rxc = 1'b0;
        tick();
        check("rts_up", 64'(rts), 64'd1);
        rx_send(8'h10);
        wait_avail("fill_first");
        check("fill_first_word", rx_word, 64'h1000000000000000);
        for (int k = 1; k <= 17; k++) begin
            rx_send(8'(8'h10 + k));
            check($sformatf("rts_k%0d", k), 64'(rts), 64'((DEPTH - (k - 1)) > MARGIN));
            check($sformatf("ovr_k%0d", k), 64'(rx_overrun), 64'(k >= 17));
        end
        wr_rxc = 1'b1; tick(); wr_rxc = 1'b0;
        check("ovr_clear", 64'(rx_overrun), 64'd0);
        for (int j = 0; j <= 16; j++) begin
            rx_take = 1'b1; tick(); rx_take = 1'b0;
            if (j == 0) begin
                tick();
                rx_send(8'h99);
                check("full_push_pop", 64'(rx_overrun), 64'd0);
            end
            wait_avail($sformatf("drain_avail_%0d", j));
            exp_b = (j == 16) ? 8'h99 : 8'(8'h11 + j);
            check($sformatf("drain_word_%0d", j), 64'(rx_word[63:56]), 64'(exp_b));
        end
        rx_take = 1'b1; tick(); rx_take = 1'b0;
        repeat (10) tick();
        check("drain_empty", 64'(rx_avail), 64'd0);

        // Reset in the middle of a send and a collect.
        do_reset();
        cmd = 4'd8; wr_txc = 1'b1; wr_rxc = 1'b1; tick(); wr_txc = 1'b0; wr_rxc = 1'b0;
        tick();
        rx_send(8'h41); rx_send(8'h42);
        tick();
        check("mid_collect", 64'(rx_nbytes), 64'd2);
        tx_word = 64'h0102030405060708; tx_load = 1'b1; txb_ready = 1'b1; cts_n = 1'b0;
        tick();
        tx_load = 1'b0;
        acc = 0; n = 0;
        while (acc < 3 && n < 100) begin
            if (txb_valid) acc++;
            tick();
            n++;
        end
        check("mid_send_bytes", 64'(acc), 64'd3);
        rst = 1'b1;
        tick();
        check("rst_mid_word", rx_word, 64'd0);
        check("rst_mid_ctl", {48'd0, tx_busy, txb_valid, txb_data, rx_nbytes, rx_avail, rts, rx_overrun},
              64'd0);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin rxb_data = 8'h77; rxb_valid = 1'b1; end
            tick();
            rxb_valid = 1'b0;
            if (txb_valid) seen++;
        end
        check("no_stray_valid", 64'(seen), 64'd0);
        check("no_stray_store", {59'd0, rx_nbytes, rx_avail}, 64'd0);
        txb_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
